// File: rtl/key_repeat_scheduler.sv
// key_repeat_scheduler: shared-timer key auto-repeat; lowest-index new press owns the timer.
// Optional repeat acceleration after eight repeats is enabled by defining KEY_REPEAT_ACCEL_EN.
module key_repeat_scheduler #(
    parameter int          NUM_KEYS            = 4,
    parameter logic [15:0] INITIAL_HOLD_CYCLES = 16'd400,
    parameter logic [15:0] REPEAT_CYCLES       = 16'd150
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_level,
    input  logic                tick_en,
    output logic                pulse_out,
    output logic [3:0]          pulse_idx,
    output logic                pulse_is_repeat,
    output logic                owner_valid,
    output logic [3:0]          owner_idx
);
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
    state_t state;
    logic [NUM_KEYS-1:0] key_q, rise;
    logic [15:0] cnt, period, limit, keys_ext;
    logic [3:0] rise_idx;
    logic any_rise, owner_held, hit;
`ifdef KEY_REPEAT_ACCEL_EN
    logic [3:0] acc;
    localparam logic [15:0] FAST_CYCLES = ((REPEAT_CYCLES >> 1) == 16'd0) ? 16'd1 : (REPEAT_CYCLES >> 1);
    assign period = (acc >= 4'd8) ? FAST_CYCLES : REPEAT_CYCLES;
`else
    assign period = REPEAT_CYCLES;
`endif
    always_comb begin
        rise = key_level & ~key_q;
        any_rise = |rise;
        rise_idx = 4'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (rise[i]) rise_idx = 4'(i);
        keys_ext = 16'(key_level);
        owner_held = keys_ext[owner_idx];
        limit = (state == DELAY) ? INITIAL_HOLD_CYCLES : period;
        hit = cnt >= limit - 16'd1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            key_q <= '0;
            cnt <= '0;
            pulse_out <= 1'b0;
            pulse_idx <= 4'd0;
            pulse_is_repeat <= 1'b0;
            owner_valid <= 1'b0;
            owner_idx <= 4'd0;
`ifdef KEY_REPEAT_ACCEL_EN
            acc <= 4'd0;
`endif
        end else begin
            key_q <= key_level;
            pulse_out <= 1'b0;
            pulse_idx <= 4'd0;
            pulse_is_repeat <= 1'b0;
            if (any_rise) begin
                state <= DELAY;
                cnt <= '0;
                owner_valid <= 1'b1;
                owner_idx <= rise_idx;
                pulse_out <= 1'b1;
                pulse_idx <= rise_idx;
`ifdef KEY_REPEAT_ACCEL_EN
                acc <= 4'd0;
`endif
            end else if (state != IDLE && !owner_held) begin
                state <= IDLE;
                cnt <= '0;
                owner_valid <= 1'b0;
                owner_idx <= 4'd0;
`ifdef KEY_REPEAT_ACCEL_EN
                acc <= 4'd0;
`endif
            end else if (state != IDLE && tick_en) begin
                if (hit) begin
                    state <= REPEAT;
                    cnt <= '0;
                    pulse_out <= 1'b1;
                    pulse_idx <= owner_idx;
                    pulse_is_repeat <= 1'b1;
`ifdef KEY_REPEAT_ACCEL_EN
                    acc <= (acc == 4'd15) ? acc : acc + 4'd1;
`endif
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_key_repeat_scheduler.sv
// tb_key_repeat_scheduler: directed vector table plus hand-written reset and long-hold sequences.
// Uses INITIAL_HOLD_CYCLES=4, REPEAT_CYCLES=2, NUM_KEYS=4.
module tb_key_repeat_scheduler;
    logic clk = 1'b0, rst = 1'b1, tick_en = 1'b1;
    logic [3:0] key_level = 4'd0;
    logic pulse_out, pulse_is_repeat, owner_valid;
    logic [3:0] pulse_idx, owner_idx;
    int n_cmp = 0, n_bad = 0;

    key_repeat_scheduler #(.NUM_KEYS(4), .INITIAL_HOLD_CYCLES(16'd4), .REPEAT_CYCLES(16'd2)) dut (
        .clk(clk), .rst(rst), .key_level(key_level), .tick_en(tick_en),
        .pulse_out(pulse_out), .pulse_idx(pulse_idx), .pulse_is_repeat(pulse_is_repeat),
        .owner_valid(owner_valid), .owner_idx(owner_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [3:0] k;
        logic       t;
        logic [10:0] e;
    } vec_t;

    function automatic logic [10:0] ex(input logic po, input logic [3:0] pi, input logic rp,
                                       input logic ov, input logic [3:0] oi);
        return {po, pi, rp, ov, oi};
    endfunction

    task automatic chk(input string name, input logic [10:0] exp);
        logic [10:0] act;
        act = {pulse_out, pulse_idx, pulse_is_repeat, owner_valid, owner_idx};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got po=%b pidx=%0d rep=%b ov=%b oidx=%0d, want po=%b pidx=%0d rep=%b ov=%b oidx=%0d",
                     name, act[10], act[9:6], act[5], act[4], act[3:0],
                     exp[10], exp[9:6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] k, input logic t, input logic [10:0] e);
        vec_t v;
        v.r = r; v.k = k; v.t = t; v.e = e;
        tbl.push_back(v);
    endtask

    initial begin
        logic [10:0] z;
        z = ex(0, 0, 0, 0, 0);
        // initial press then repeats at E4, E6, E8
        add(1, 4'b0000, 1, z);
        add(0, 4'b0000, 1, z);
        add(0, 4'b0010, 1, ex(1, 1, 0, 1, 1));
        add(0, 4'b0010, 1, ex(0, 0, 0, 1, 1));
        add(0, 4'b0010, 1, ex(0, 0, 0, 1, 1));
        add(0, 4'b0010, 1, ex(0, 0, 0, 1, 1));
        add(0, 4'b0010, 1, ex(1, 1, 1, 1, 1));
        add(0, 4'b0010, 1, ex(0, 0, 0, 1, 1));
        add(0, 4'b0010, 1, ex(1, 1, 1, 1, 1));
        add(0, 4'b0010, 1, ex(0, 0, 0, 1, 1));
        add(0, 4'b0010, 1, ex(1, 1, 1, 1, 1));
        add(0, 4'b0000, 1, z);
        // simultaneous rises: lowest index wins, still-held key 3 never gains ownership
        add(0, 4'b1100, 1, ex(1, 2, 0, 1, 2));
        add(0, 4'b1100, 1, ex(0, 0, 0, 1, 2));
        add(0, 4'b1100, 1, ex(0, 0, 0, 1, 2));
        add(0, 4'b1100, 1, ex(0, 0, 0, 1, 2));
        add(0, 4'b1100, 1, ex(1, 2, 1, 1, 2));
        add(0, 4'b1000, 1, z);
        add(0, 4'b1000, 1, z);
        add(0, 4'b1000, 1, z);
        add(0, 4'b0000, 1, z);
        // key 0 in REPEAT, key 3 takes over and restarts the initial delay
        add(0, 4'b0001, 1, ex(1, 0, 0, 1, 0));
        add(0, 4'b0001, 1, ex(0, 0, 0, 1, 0));
        add(0, 4'b0001, 1, ex(0, 0, 0, 1, 0));
        add(0, 4'b0001, 1, ex(0, 0, 0, 1, 0));
        add(0, 4'b0001, 1, ex(1, 0, 1, 1, 0));
        add(0, 4'b1001, 1, ex(1, 3, 0, 1, 3));
        add(0, 4'b1001, 1, ex(0, 0, 0, 1, 3));
        add(0, 4'b1001, 1, ex(0, 0, 0, 1, 3));
        add(0, 4'b1001, 1, ex(0, 0, 0, 1, 3));
        add(0, 4'b1001, 1, ex(1, 3, 1, 1, 3));
        // owner release and new rise in the same cycle: the rise wins
        add(0, 4'b0100, 1, ex(1, 2, 0, 1, 2));
        add(0, 4'b0000, 1, z);
        // tick_en alternating: first repeat on the fourth enabled tick
        add(0, 4'b0001, 1, ex(1, 0, 0, 1, 0));
        for (int e = 1; e <= 7; e++) add(0, 4'b0001, e % 2 == 0, ex(0, 0, 0, 1, 0));
        add(0, 4'b0001, 1, ex(1, 0, 1, 1, 0));
        add(0, 4'b0001, 0, ex(0, 0, 0, 1, 0));
        add(0, 4'b0000, 1, z);

        #2;
        foreach (tbl[i]) begin
            rst = tbl[i].r; key_level = tbl[i].k; tick_en = tbl[i].t;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), tbl[i].e);
        end

        // asynchronous reset in the middle of DELAY
        tick_en = 1'b1; key_level = 4'b0001;
        @(posedge clk); #1;
        chk("rst_pre_pulse", ex(1, 0, 0, 1, 0));
        @(posedge clk); #1;
        chk("rst_pre_delay", ex(0, 0, 0, 1, 0));
        #2 rst = 1'b1;
        #1 chk("rst_async", ex(0, 0, 0, 0, 0));
        @(posedge clk); #1;
        chk("rst_hold", ex(0, 0, 0, 0, 0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_release_press", ex(1, 0, 0, 1, 0));
        key_level = 4'b0000;
        @(posedge clk); #1;
        chk("rst_idle", ex(0, 0, 0, 0, 0));

        // long hold: repeat spacing, accelerated after eight repeats when enabled
        key_level = 4'b0010;
        for (int e = 0; e < 24; e++) begin
            logic po;
`ifdef KEY_REPEAT_ACCEL_EN
            po = (e == 0) || (e >= 4 && e <= 18 && e % 2 == 0) || (e >= 19);
`else
            po = (e == 0) || (e >= 4 && e % 2 == 0);
`endif
            @(posedge clk); #1;
            chk($sformatf("hold_e%0d", e), po ? ex(1, 1, e != 0, 1, 1) : ex(0, 0, 0, 1, 1));
        end
        key_level = 4'b0000;
        @(posedge clk); #1;
        chk("hold_release", ex(0, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
